// File: rtl/trb_local_bus_bridge.sv
// TRBNet slow-control to local-bus bridge: decodes one register page, strobes one of
// NUM_CH local banks and returns its ack/data, a nack on timeout, or unknown on a decode miss.
module trb_local_bus_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'h9000,
  parameter int          LOCAL_AW  = 6,
  parameter int          NUM_CH    = 4,
  parameter int          TIMEOUT   = 15
) (
  input  logic                  clk_100_i,
  input  logic                  reset_i,
  input  logic [15:0]           bus_addr_i,
  input  logic [31:0]           bus_data_i,
  input  logic                  bus_wr_i,
  input  logic                  bus_rd_i,
  output logic [31:0]           bus_data_o,
  output logic                  bus_ack_o,
  output logic                  bus_nack_o,
  output logic                  bus_unknown_o,
  output logic [LOCAL_AW-1:0]   lb_addr_o,
  output logic [31:0]           lb_data_o,
  output logic [NUM_CH-1:0]     lb_wr_o,
  output logic [NUM_CH-1:0]     lb_rd_o,
  input  logic [32*NUM_CH-1:0]  lb_data_i,
  input  logic [NUM_CH-1:0]     lb_ack_i
);

  localparam int                CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                PAGE_LSB  = LOCAL_AW + CH_BITS;
  localparam logic [7:0]        TIMEOUT_V = 8'(TIMEOUT);
  localparam logic [CH_BITS:0]  NUM_CH_V  = (CH_BITS+1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic                 dir_q, dir_d;
  logic [7:0]           timer_q, timer_d;
  logic [LOCAL_AW-1:0]  lb_addr_d;
  logic [31:0]          lb_data_d, bus_data_d;
  logic [NUM_CH-1:0]    lb_wr_d, lb_rd_d;
  logic                 ack_d, nack_d, unk_d;

  logic [CH_BITS-1:0]   req_ch;
  logic                 page_hit;

  assign req_ch   = bus_addr_i[PAGE_LSB-1:LOCAL_AW];
  assign page_hit = (bus_addr_i[15:PAGE_LSB] == BASE_ADDR[15:PAGE_LSB]);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    lb_addr_d  = lb_addr_o;
    lb_data_d  = lb_data_o;
    lb_wr_d    = '0;
    lb_rd_d    = '0;
    bus_data_d = bus_data_o;
    ack_d      = 1'b0;
    nack_d     = 1'b0;
    unk_d      = 1'b0;
    case (state_q)
      WAIT: begin
        // an ack in the same cycle as the timeout still completes the transfer
        if (lb_ack_i[ch_q]) begin
          if (dir_q) bus_data_d = lb_data_i[32*int'(ch_q) +: 32];
          ack_d   = 1'b1;
          timer_d = '0;
          state_d = RESP;
        end else if (timer_q == TIMEOUT_V) begin
          nack_d  = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        // RESP accepts requests like IDLE so back-to-back transfers need no gap
        state_d = IDLE;
        if (bus_wr_i && bus_rd_i) begin
          nack_d = 1'b1;
        end else if (bus_wr_i || bus_rd_i) begin
          if (!page_hit || ({1'b0, req_ch} >= NUM_CH_V)) begin
            unk_d = 1'b1;
          end else begin
            ch_d      = req_ch;
            dir_d     = bus_rd_i;
            lb_addr_d = bus_addr_i[LOCAL_AW-1:0];
            lb_data_d = bus_data_i;
            if (bus_rd_i) lb_rd_d = NUM_CH'(1) << req_ch;
            else          lb_wr_d = NUM_CH'(1) << req_ch;
            timer_d   = '0;
            state_d   = WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_100_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      dir_q         <= 1'b0;
      timer_q       <= '0;
      lb_addr_o     <= '0;
      lb_data_o     <= '0;
      lb_wr_o       <= '0;
      lb_rd_o       <= '0;
      bus_data_o    <= '0;
      bus_ack_o     <= 1'b0;
      bus_nack_o    <= 1'b0;
      bus_unknown_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      dir_q         <= dir_d;
      timer_q       <= timer_d;
      lb_addr_o     <= lb_addr_d;
      lb_data_o     <= lb_data_d;
      lb_wr_o       <= lb_wr_d;
      lb_rd_o       <= lb_rd_d;
      bus_data_o    <= bus_data_d;
      bus_ack_o     <= ack_d;
      bus_nack_o    <= nack_d;
      bus_unknown_o <= unk_d;
    end
  end

endmodule

// File: tb/tb_trb_local_bus_bridge.sv
// Directed bench for trb_local_bus_bridge: a 4-channel and a 3-channel instance,
// inputs driven and outputs sampled on the falling edge.
module tb_trb_local_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 4-channel instance
  logic         rst, wr, rd, ack, nack, unk;
  logic [15:0]  addr;
  logic [31:0]  wdat, rdat, lb_wdat;
  logic [5:0]   lb_addr;
  logic [3:0]   lb_wr, lb_rd, lb_ack;
  logic [127:0] lb_rdat;

  // 3-channel instance
  logic         u3_rst, u3_wr, u3_rd, u3_ack, u3_nack, u3_unk;
  logic [15:0]  u3_addr;
  logic [31:0]  u3_wdat, u3_rdat, u3_lb_wdat;
  logic [5:0]   u3_lb_addr;
  logic [2:0]   u3_lb_wr, u3_lb_rd, u3_lb_ack;
  logic [95:0]  u3_lb_rdat;

  trb_local_bus_bridge dut (
    .clk_100_i(clk), .reset_i(rst),
    .bus_addr_i(addr), .bus_data_i(wdat), .bus_wr_i(wr), .bus_rd_i(rd),
    .bus_data_o(rdat), .bus_ack_o(ack), .bus_nack_o(nack), .bus_unknown_o(unk),
    .lb_addr_o(lb_addr), .lb_data_o(lb_wdat), .lb_wr_o(lb_wr), .lb_rd_o(lb_rd),
    .lb_data_i(lb_rdat), .lb_ack_i(lb_ack)
  );

  trb_local_bus_bridge #(.NUM_CH(3)) dut3 (
    .clk_100_i(clk), .reset_i(u3_rst),
    .bus_addr_i(u3_addr), .bus_data_i(u3_wdat), .bus_wr_i(u3_wr), .bus_rd_i(u3_rd),
    .bus_data_o(u3_rdat), .bus_ack_o(u3_ack), .bus_nack_o(u3_nack), .bus_unknown_o(u3_unk),
    .lb_addr_o(u3_lb_addr), .lb_data_o(u3_lb_wdat), .lb_wr_o(u3_lb_wr), .lb_rd_o(u3_lb_rd),
    .lb_data_i(u3_lb_rdat), .lb_ack_i(u3_lb_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic [15:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a; wdat = d; wr = w; rd = r;
  endtask

  task automatic req3(input logic [15:0] a, input logic w, input logic r);
    u3_addr = a; u3_wdat = 32'h0; u3_wr = w; u3_rd = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; u3_rst = 1'b1;
    req(16'h0, 32'h0, 1'b0, 1'b0); lb_ack = '0; lb_rdat = '0;
    req3(16'h0, 1'b0, 1'b0); u3_lb_ack = '0; u3_lb_rdat = '0;
    repeat (3) step();
    check("rst_flags", 32'({ack, nack, unk, lb_wr, lb_rd}), 32'h0);
    check("rst_rdat", rdat, 32'h0);
    check("rst_lb", 32'({lb_addr}) | lb_wdat, 32'h0);
    check("rst3_flags", 32'({u3_ack, u3_nack, u3_unk, u3_lb_wr, u3_lb_rd}), 32'h0);
    rst = 1'b0; u3_rst = 1'b0;

    // 1: write ch1, ack in the local strobe cycle
    step(); req(16'h9045, 32'hDEADBEEF, 1'b1, 1'b0);
    step(); wr = 1'b0;
    check("t1_lb_wr", 32'(lb_wr), 32'h2);
    check("t1_lb_addr", 32'(lb_addr), 32'h05);
    check("t1_lb_data", lb_wdat, 32'hDEADBEEF);
    check("t1_ack_early", 32'(ack), 32'h0);
    lb_ack = 4'b0010;
    step(); lb_ack = '0;
    check("t1_resp", 32'({ack, nack, unk}), 32'h4);
    step();
    check("t1_ack_pulse", 32'({ack, lb_wr}), 32'h0);

    // 2: read ch3, ack at T+4, foreign ack at T+2 ignored
    req(16'h90C3, 32'h0, 1'b0, 1'b1);
    step(); rd = 1'b0;
    check("t2_lb_rd", 32'(lb_rd), 32'h8);
    check("t2_lb_addr", 32'(lb_addr), 32'h03);
    step();
    check("t2_lb_rd_pulse", 32'(lb_rd), 32'h0);
    lb_rdat[31:0] = 32'hFFFF0000; lb_ack = 4'b0001;
    step(); lb_ack = '0;
    check("t2_foreign_ack", 32'({ack, nack, unk}), 32'h0);
    step(); lb_rdat[127:96] = 32'h12345678; lb_ack = 4'b1000;
    step(); lb_ack = '0;
    check("t2_ack", 32'({ack, nack, unk}), 32'h4);
    check("t2_rdat", rdat, 32'h12345678);

    // 3: timeout, late ack ignored
    step(); req(16'h9001, 32'h0, 1'b0, 1'b1);
    step(); rd = 1'b0;
    repeat (14) step();
    step();
    check("t3_nack_T16", 32'({ack, nack, unk}), 32'h0);
    step();
    check("t3_nack_T17", 32'({ack, nack, unk}), 32'h2);
    check("t3_rdat_hold", rdat, 32'h12345678);
    step();
    check("t3_nack_pulse", 32'(nack), 32'h0);
    step();
    step(); lb_rdat[31:0] = 32'hCAFEF00D; lb_ack = 4'b0001;
    step(); lb_ack = '0;
    check("t3_late_ack", 32'({ack, nack, unk}), 32'h0);
    check("t3_rdat_late", rdat, 32'h12345678);

    // 4: decode misses and wr+rd collision
    req(16'h8F00, 32'h1, 1'b1, 1'b0);
    step();
    check("t4_unk_wr", 32'({ack, nack, unk, lb_wr}), 32'h10);
    req(16'h9100, 32'h0, 1'b0, 1'b1);
    step();
    check("t4_unk_rd", 32'({ack, nack, unk, lb_rd}), 32'h10);
    req(16'h9000, 32'h0, 1'b1, 1'b1);
    step(); wr = 1'b0; rd = 1'b0;
    check("t4_both", 32'({ack, nack, unk, lb_wr, lb_rd}), 32'h200);
    step();
    check("t4_idle", 32'({ack, nack, unk}), 32'h0);

    // back-to-back: new request in the ack cycle
    req(16'h9000, 32'h0, 1'b0, 1'b1);
    step(); rd = 1'b0; lb_rdat[31:0] = 32'hA5A5A5A5; lb_ack = 4'b0001;
    step(); lb_ack = '0;
    check("b2b_ack1", 32'({ack, nack, unk}), 32'h4);
    check("b2b_rdat1", rdat, 32'hA5A5A5A5);
    req(16'h9040, 32'h11112222, 1'b1, 1'b0);
    step(); wr = 1'b0;
    check("b2b_lb_wr", 32'({ack, lb_wr}), 32'h2);
    check("b2b_lb_data", lb_wdat, 32'h11112222);
    lb_ack = 4'b0010;
    step(); lb_ack = '0;
    check("b2b_ack2", 32'({ack, nack, unk}), 32'h4);
    check("b2b_rdat2", rdat, 32'hA5A5A5A5);

    // 5: three-channel instance
    req3(16'h90C0, 1'b0, 1'b1);
    step(); u3_rd = 1'b0;
    check("t5_unk_ch3", 32'({u3_ack, u3_nack, u3_unk, u3_lb_rd}), 32'h8);
    req3(16'h9000, 1'b0, 1'b1);
    step(); u3_rd = 1'b0;
    check("t5_lb_rd", 32'(u3_lb_rd), 32'h1);
    step(); u3_rst = 1'b1; #1;
    check("t5_rst_flags", 32'({u3_ack, u3_nack, u3_unk, u3_lb_wr, u3_lb_rd}), 32'h0);
    check("t5_rst_lb", 32'(u3_lb_addr) | u3_rdat, 32'h0);
    u3_lb_rdat[31:0] = 32'h77; u3_lb_ack = 3'b001;
    step(); u3_rst = 1'b0;
    step();
    step(); u3_lb_ack = '0;
    check("t5_no_resp", 32'({u3_ack, u3_nack, u3_unk}), 32'h0);
    check("t5_rdat_clear", u3_rdat, 32'h0);
    req3(16'h9000, 1'b0, 1'b1); u3_lb_rdat[31:0] = 32'h0BADCAFE;
    step(); u3_rd = 1'b0; u3_lb_ack = 3'b001;
    step(); u3_lb_ack = '0;
    check("t5_ack", 32'({u3_ack, u3_nack, u3_unk}), 32'h4);
    check("t5_rdat", u3_rdat, 32'h0BADCAFE);
    req3(16'h9040, 1'b0, 1'b1);
    step(); u3_rd = 1'b0;
    check("t5_lb_rd_ch1", 32'(u3_lb_rd), 32'h2);
    req3(16'h9000, 1'b1, 1'b0);
    step(); u3_wr = 1'b0;
    check("t5_drop", 32'({u3_ack, u3_nack, u3_unk, u3_lb_wr}), 32'h0);
    u3_lb_rdat[63:32] = 32'h5555AAAA; u3_lb_ack = 3'b010;
    step(); u3_lb_ack = '0;
    check("t5_ack_ch1", 32'({u3_ack, u3_nack, u3_unk}), 32'h4);
    check("t5_rdat_ch1", u3_rdat, 32'h5555AAAA);
    step();
    check("t5_drop_after", 32'({u3_ack, u3_nack, u3_unk, u3_lb_wr}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
